// File: rtl/pipeline_run_monitor_pkg.sv
// Shared types and constants for the pipeline run monitor and its benches.
// Channel indices follow the default tap order: t0-t7 first, then s0-s7.
package pipeline_run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } run_state_t;

    localparam int DEF_PC_W   = 7;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NUM_CH = 16;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;
    localparam int T7 = 7;
    localparam int S0 = 8;
    localparam int S1 = 9;
    localparam int S2 = 10;
    localparam int S3 = 11;
    localparam int S4 = 12;
    localparam int S5 = 13;
    localparam int S6 = 14;
    localparam int S7 = 15;

endpackage

// File: rtl/pipeline_run_monitor_stall.sv
// Halt detector: tracks how many consecutive cycles the core PC has not moved.
// halt is combinational and only meaningful while the owner has enable high.
module pc_stall_detector
    import pipeline_run_monitor_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int STALL_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            enable,
    input  logic [PC_W-1:0] pc,
    output logic            halt
);

    // Counter must hold STALL_LIMIT itself, reached on the halting edge.
    localparam int SC_W = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);

    logic [PC_W-1:0] prev_pc_reg;
    logic [SC_W-1:0] stall_cnt_reg;
    logic            pc_same;

    assign pc_same = (pc == prev_pc_reg);
    assign halt    = pc_same && (stall_cnt_reg == SC_W'(STALL_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pc_reg   <= '0;
            stall_cnt_reg <= '0;
        end else if (clear) begin
            prev_pc_reg   <= pc;
            stall_cnt_reg <= '0;
        end else if (enable) begin
            prev_pc_reg   <= pc;
            stall_cnt_reg <= pc_same ? stall_cnt_reg + SC_W'(1) : '0;
        end
    end

endmodule

// File: rtl/pipeline_run_monitor.sv
// Run monitor beside the 5-stage core: counts run cycles, stops on PC halt or
// cycle budget, flags per-cycle register changes and freezes a register snapshot.
module pipeline_run_monitor
    import pipeline_run_monitor_pkg::*;
#(
    parameter int PC_W        = DEF_PC_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = 16,
    parameter int MAX_CYCLES  = 29,
    parameter int STALL_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [PC_W-1:0]           pc,
    input  logic [NUM_CH*DATA_W-1:0]  regs,
    input  logic [$clog2(NUM_CH)-1:0] rd_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [CNT_W-1:0]          cycle_count,
    output logic [NUM_CH-1:0]         change_mask,
    output logic                      change_valid,
    output logic [DATA_W-1:0]         rd_data
);

    if (MAX_CYCLES < 1) begin : g_bad_max_low
        $error("pipeline_run_monitor: MAX_CYCLES must be at least 1");
    end
    if (longint'(MAX_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_max_high
        $error("pipeline_run_monitor: MAX_CYCLES must be below 2**CNT_W");
    end
    if (STALL_LIMIT < 1) begin : g_bad_stall
        $error("pipeline_run_monitor: STALL_LIMIT must be at least 1");
    end
    if (NUM_CH < 2) begin : g_bad_ch
        $error("pipeline_run_monitor: NUM_CH must be at least 2");
    end

    run_state_t              state_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    timeout_reg;
    logic [CNT_W-1:0]        cycle_count_reg;
    logic [NUM_CH-1:0]       change_mask_reg;
    logic                    change_valid_reg;
    logic [DATA_W-1:0]       prev_regs_reg [NUM_CH];
    logic [DATA_W-1:0]       snapshot_reg  [NUM_CH];
    logic [NUM_CH-1:0]       diff;
    logic                    launch;
    logic                    run_step;
    logic                    halt;
    logic                    at_budget;
    logic                    snap_we;

    assign launch    = start && (state_reg != RUN);
    assign run_step  = (state_reg == RUN) && !abort;
    assign at_budget = (cycle_count_reg == CNT_W'(MAX_CYCLES - 1));
    assign snap_we   = run_step && (halt || at_budget);

    pc_stall_detector #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (launch),
        .enable (run_step),
        .pc     (pc),
        .halt   (halt)
    );

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign diff[gi] = (regs[gi*DATA_W +: DATA_W] != prev_regs_reg[gi]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev_regs_reg[gi] <= '0;
                snapshot_reg[gi]  <= '0;
            end else begin
                if (launch || run_step) begin
                    prev_regs_reg[gi] <= regs[gi*DATA_W +: DATA_W];
                end
                if (snap_we) begin
                    snapshot_reg[gi] <= regs[gi*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            timeout_reg      <= 1'b0;
            cycle_count_reg  <= '0;
            change_mask_reg  <= '0;
            change_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg        <= RUN;
                        busy_reg         <= 1'b1;
                        done_reg         <= 1'b0;
                        timeout_reg      <= 1'b0;
                        cycle_count_reg  <= '0;
                        change_mask_reg  <= '0;
                        change_valid_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Cancelled runs leave the count visible but raise no flags.
                        state_reg        <= IDLE;
                        busy_reg         <= 1'b0;
                        change_mask_reg  <= '0;
                        change_valid_reg <= 1'b0;
                    end else begin
                        cycle_count_reg <= cycle_count_reg + CNT_W'(1);
                        if (halt || at_budget) begin
                            state_reg        <= DONE;
                            busy_reg         <= 1'b0;
                            done_reg         <= 1'b1;
                            timeout_reg      <= !halt;
                            change_mask_reg  <= '0;
                            change_valid_reg <= 1'b0;
                        end else begin
                            change_mask_reg  <= diff;
                            change_valid_reg <= |diff;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        if (32'(rd_sel) < NUM_CH) begin
            rd_data = snapshot_reg[rd_sel];
        end
    end

    assign busy         = busy_reg;
    assign done         = done_reg;
    assign timeout      = timeout_reg;
    assign cycle_count  = cycle_count_reg;
    assign change_mask  = change_mask_reg;
    assign change_valid = change_valid_reg;

endmodule
